// File: rtl/miner_array_ctrl.sv
// miner_array_ctrl: spreads a nonce search across NUM_CORES hash lanes.
// Lane i tests base+i, base+i+NUM_CORES, ... (mod 2^NONCE_W), reports the
// lowest-lane first hit, drains outstanding requests and pulses done.
module miner_array_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int CNT_W     = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NONCE_W-1:0]             base_nonce,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic                           exhausted,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [CNT_W-1:0]               hash_count,
  output logic [NUM_CORES-1:0]           core_req,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_ack,
  input  logic [NUM_CORES-1:0]           core_hit
);

  localparam int LANE_BITS = $clog2(NUM_CORES);
  // One extra bit so a lane counter can hold its full share 2^NONCE_W/NUM_CORES.
  localparam int STEP_W = NONCE_W - LANE_BITS + 1;
  localparam logic [STEP_W-1:0] STEP_LIMIT = {1'b1, {(STEP_W-1){1'b0}}};
  localparam logic [NONCE_W-1:0] NONCE_STRIDE = NONCE_W'(NUM_CORES);
  localparam int POP_W = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [NONCE_W-1:0]    lane_nonce_q [NUM_CORES];
  logic [NONCE_W-1:0]    lane_nonce_d [NUM_CORES];
  logic [STEP_W-1:0]     lane_steps_q [NUM_CORES];
  logic [STEP_W-1:0]     lane_steps_d [NUM_CORES];
  logic [NUM_CORES-1:0]  req_q, req_d;
  logic                  found_q, found_d;
  logic                  exhausted_q, exhausted_d;
  logic [NONCE_W-1:0]    found_nonce_q, found_nonce_d;
  logic [CNT_W-1:0]      hash_count_q, hash_count_d;

  logic [NUM_CORES-1:0]  ack_v;
  logic [NUM_CORES-1:0]  hit_v;
  logic [NUM_CORES-1:0]  retired;
  logic [POP_W-1:0]      ack_pop;
  logic [CNT_W:0]        count_sum;
  logic [CNT_W-1:0]      count_sat;
  logic [NONCE_W-1:0]    hit_nonce;

  // Qualify acks/hits against live requests, pick the lowest-index hit and form the saturating count.
  always_comb begin
    ack_v     = core_ack & req_q;
    hit_v     = ack_v & core_hit;
    ack_pop   = '0;
    hit_nonce = '0;
    retired   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      ack_pop    = ack_pop + POP_W'(ack_v[i]);
      retired[i] = (lane_steps_q[i] == STEP_LIMIT);
      if (hit_v[i]) begin
        hit_nonce = lane_nonce_q[i];
      end
    end
    count_sum = {1'b0, hash_count_q} + (CNT_W+1)'(ack_pop);
    count_sat = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
  end

  // Next-state logic for the search FSM and per-lane request bookkeeping.
  always_comb begin
    state_d       = state_q;
    lane_nonce_d  = lane_nonce_q;
    lane_steps_d  = lane_steps_q;
    req_d         = req_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    found_nonce_d = found_nonce_q;
    hash_count_d  = hash_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            lane_nonce_d[i] = base_nonce + NONCE_W'(i);
            lane_steps_d[i] = '0;
          end
          req_d         = '1;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          found_nonce_d = '0;
          hash_count_d  = '0;
          state_d       = RUN;
        end
      end
      RUN: begin
        hash_count_d = count_sat;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (ack_v[i]) begin
            lane_steps_d[i] = lane_steps_q[i] + STEP_W'(1);
          end
        end
        if (|hit_v) begin
          found_d       = 1'b1;
          found_nonce_d = hit_nonce;
          req_d         = req_q & ~core_ack;
          state_d       = DRAIN;
        end else if (&retired) begin
          exhausted_d = 1'b1;
          state_d     = DONE;
        end else if (abort) begin
          req_d   = req_q & ~core_ack;
          state_d = DRAIN;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (ack_v[i]) begin
              if (lane_steps_d[i] == STEP_LIMIT) begin
                req_d[i] = 1'b0;
              end else begin
                lane_nonce_d[i] = lane_nonce_q[i] + NONCE_STRIDE;
              end
            end
          end
        end
      end
      DRAIN: begin
        hash_count_d = count_sat;
        req_d        = req_q & ~core_ack;
        if (req_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops every request without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < NUM_CORES; i++) begin
        lane_nonce_q[i] <= '0;
        lane_steps_q[i] <= '0;
      end
      req_q         <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
      hash_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      lane_nonce_q  <= lane_nonce_d;
      lane_steps_q  <= lane_steps_d;
      req_q         <= req_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      found_nonce_q <= found_nonce_d;
      hash_count_q  <= hash_count_d;
    end
  end

  // Drive outputs straight from registered state and pack the lane nonces.
  always_comb begin
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = (state_q == DONE);
    found       = found_q;
    exhausted   = exhausted_q;
    found_nonce = found_nonce_q;
    hash_count  = hash_count_q;
    core_req    = req_q;
    core_nonce  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_nonce[i*NONCE_W +: NONCE_W] = lane_nonce_q[i];
    end
  end

endmodule

// File: tb/tb_miner_array_ctrl.sv
// tb_miner_array_ctrl: directed checks of miner_array_ctrl with a behavioural
// hash-core responder (per-lane latency and hit nonce) on an 8-bit nonce space.
module tb_miner_array_ctrl;

  localparam int NC = 4;
  localparam int NW = 8;
  localparam int CW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NW-1:0]     base_nonce = '0;
  logic              busy;
  logic              done;
  logic              found;
  logic              exhausted;
  logic [NW-1:0]     found_nonce;
  logic [CW-1:0]     hash_count;
  logic [NC-1:0]     core_req;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC-1:0]     core_ack = '0;
  logic [NC-1:0]     core_hit = '0;

  int            lat [NC];
  bit            hit_en [NC];
  logic [NW-1:0] hit_nonce [NC];

  int            wait_cnt [NC] = '{default: 0};
  logic [NW-1:0] req_nonce [NC];
  int            req_count [NC] = '{default: 0};
  int            unstable_count = 0;
  int            done_pulses = 0;
  logic [NW-1:0] lane0_log [$];

  int            req_base [NC];
  int            assert_count = 0;
  int            fail_count = 0;

  miner_array_ctrl #(.NUM_CORES(NC), .NONCE_W(NW), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .base_nonce  (base_nonce),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce),
    .hash_count  (hash_count),
    .core_req    (core_req),
    .core_nonce  (core_nonce),
    .core_ack    (core_ack),
    .core_hit    (core_hit)
  );

  // Free-running mining clock.
  always #5 clock = ~clock;

  // Hash-core model: acks each request after lat[i] cycles, logs nonces and counts done pulses.
  always @(negedge clock) begin
    if (done === 1'b1) done_pulses++;
    for (int i = 0; i < NC; i++) begin
      if (core_ack[i]) begin
        core_ack[i] = 1'b0;
        core_hit[i] = 1'b0;
        wait_cnt[i] = 0;
      end
      if (core_req[i] === 1'b1) begin
        if (wait_cnt[i] == 0) begin
          req_nonce[i] = core_nonce[i*NW +: NW];
          req_count[i]++;
          if (i == 0) lane0_log.push_back(core_nonce[NW-1:0]);
        end else if (core_nonce[i*NW +: NW] !== req_nonce[i]) begin
          unstable_count++;
        end
        wait_cnt[i]++;
        if (wait_cnt[i] >= lat[i]) begin
          core_ack[i] = 1'b1;
          core_hit[i] = hit_en[i] && (core_nonce[i*NW +: NW] == hit_nonce[i]);
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [NW-1:0] b);
    start      = s;
    abort      = a;
    base_nonce = b;
    tick();
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitDone(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < max_cycles && !seen; n++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic setCores(input int l, input logic [NW-1:0] n0, n1, n2, n3, input bit [3:0] en);
    for (int k = 0; k < NC; k++) begin
      lat[k]    = l;
      hit_en[k] = en[k];
    end
    hit_nonce[0] = n0;
    hit_nonce[1] = n1;
    hit_nonce[2] = n2;
    hit_nonce[3] = n3;
  endtask

  task automatic snapReqs();
    for (int k = 0; k < NC; k++) req_base[k] = req_count[k];
  endtask

  function automatic int newReqs(input int lane);
    return req_count[lane] - req_base[lane];
  endfunction

  // Directed test sequence.
  initial begin
    bit seen;
    int pulses0;
    int size0;

    $display("[TB] starting miner_array_ctrl directed test");
    setCores(3, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_found", found, 0);
    checkOutput("rst_exhausted", exhausted, 0);
    checkOutput("rst_found_nonce", found_nonce, 0);
    checkOutput("rst_hash_count", hash_count, 0);
    checkOutput("rst_core_req", core_req, 0);
    checkOutput("rst_core_nonce", core_nonce, 0);

    // Lane 2 hits on its second request.
    $display("[TB] single hit on lane 2");
    setCores(3, 8'h00, 8'h00, 8'h16, 8'h00, 4'b0100);
    pulses0 = done_pulses;
    snapReqs();
    applyStimulus(1'b1, 1'b0, 8'h10);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_core_req", core_req, 4'hF);
    checkOutput("t1_core_nonce", core_nonce, 32'h13121110);
    waitDone(100, seen);
    checkOutput("t1_done_seen", seen, 1);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_found", found, 1);
    checkOutput("t1_found_nonce", found_nonce, 8'h16);
    checkOutput("t1_exhausted", exhausted, 0);
    checkOutput("t1_hash_count", hash_count, 8);
    tick();
    tick();
    checkOutput("t1_done_pulses", done_pulses - pulses0, 1);
    checkOutput("t1_lane2_reqs", newReqs(2), 2);

    // Lanes 1 and 3 hit together; lanes 0 and 2 drain and their hits are ignored.
    $display("[TB] simultaneous hits with drain");
    setCores(3, 8'h10, 8'h11, 8'h12, 8'h13, 4'b1111);
    lat[0] = 5;
    lat[2] = 6;
    pulses0 = done_pulses;
    snapReqs();
    applyStimulus(1'b1, 1'b0, 8'h10);
    repeat (3) tick();
    checkOutput("t2_drain_req", core_req, 4'b0101);
    checkOutput("t2_drain_busy", busy, 1);
    checkOutput("t2_drain_found", found, 1);
    checkOutput("t2_drain_nonce", found_nonce, 8'h11);
    waitDone(100, seen);
    checkOutput("t2_done_seen", seen, 1);
    checkOutput("t2_found_nonce", found_nonce, 8'h11);
    checkOutput("t2_hash_count", hash_count, 4);
    tick();
    tick();
    checkOutput("t2_done_pulses", done_pulses - pulses0, 1);
    checkOutput("t2_total_reqs", newReqs(0) + newReqs(1) + newReqs(2) + newReqs(3), 4);

    // Full 8-bit space from 0xFE with no hits.
    $display("[TB] exhaustion from 0xFE");
    setCores(1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    pulses0 = done_pulses;
    size0 = lane0_log.size();
    snapReqs();
    applyStimulus(1'b1, 1'b0, 8'hFE);
    checkOutput("t3_core_nonce", core_nonce, 32'h0100FFFE);
    waitDone(200, seen);
    checkOutput("t3_done_seen", seen, 1);
    checkOutput("t3_exhausted", exhausted, 1);
    checkOutput("t3_found", found, 0);
    checkOutput("t3_hash_count", hash_count, 256);
    checkOutput("t3_lane0_reqs", lane0_log.size() - size0, 64);
    checkOutput("t3_lane0_n0", lane0_log[size0], 8'hFE);
    checkOutput("t3_lane0_n1", lane0_log[size0+1], 8'h02);
    checkOutput("t3_lane0_n2", lane0_log[size0+2], 8'h06);
    checkOutput("t3_lane0_n63", lane0_log[size0+63], 8'hFA);
    checkOutput("t3_lane3_reqs", newReqs(3), 64);
    tick();
    tick();
    checkOutput("t3_done_pulses", done_pulses - pulses0, 1);

    // Abort five cycles into RUN with all requests outstanding.
    $display("[TB] abort mid-search");
    setCores(8, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    pulses0 = done_pulses;
    snapReqs();
    applyStimulus(1'b1, 1'b0, 8'h50);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b1, 8'h50);
    checkOutput("t4_busy", busy, 1);
    checkOutput("t4_req_held", core_req, 4'hF);
    waitDone(100, seen);
    checkOutput("t4_done_seen", seen, 1);
    checkOutput("t4_found", found, 0);
    checkOutput("t4_exhausted", exhausted, 0);
    checkOutput("t4_hash_count", hash_count, 4);
    tick();
    tick();
    checkOutput("t4_total_reqs", newReqs(0) + newReqs(1) + newReqs(2) + newReqs(3), 4);
    checkOutput("t4_done_pulses", done_pulses - pulses0, 1);

    // Start while busy is ignored; start after done clears results.
    $display("[TB] start while busy and restart");
    setCores(3, 8'h48, 8'h00, 8'h00, 8'h00, 4'b0001);
    applyStimulus(1'b1, 1'b0, 8'h40);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 8'h80);
    checkOutput("t5_lane0_nonce", core_nonce[NW-1:0], 8'h44);
    checkOutput("t5_mid_count", hash_count, 4);
    checkOutput("t5_mid_busy", busy, 1);
    waitDone(100, seen);
    checkOutput("t5_done_seen", seen, 1);
    checkOutput("t5_found_nonce", found_nonce, 8'h48);
    checkOutput("t5_hash_count", hash_count, 12);
    tick();
    tick();
    setCores(3, 8'h00, 8'h21, 8'h00, 8'h00, 4'b0010);
    applyStimulus(1'b1, 1'b0, 8'h20);
    checkOutput("t5_restart_found", found, 0);
    checkOutput("t5_restart_nonce", found_nonce, 0);
    checkOutput("t5_restart_count", hash_count, 0);
    checkOutput("t5_restart_busy", busy, 1);
    checkOutput("t5_restart_lanes", core_nonce, 32'h23222120);
    waitDone(100, seen);
    checkOutput("t5_restart_done", seen, 1);
    checkOutput("t5_restart_result", found_nonce, 8'h21);
    checkOutput("t5_restart_hashes", hash_count, 4);
    tick();
    tick();

    // Reset mid-RUN clears everything without a done pulse.
    $display("[TB] reset mid-search");
    setCores(3, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) tick();
    pulses0 = done_pulses;
    reset = 1'b1;
    tick();
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_found", found, 0);
    checkOutput("t6_found_nonce", found_nonce, 0);
    checkOutput("t6_hash_count", hash_count, 0);
    checkOutput("t6_core_req", core_req, 0);
    checkOutput("t6_core_nonce", core_nonce, 0);
    reset = 1'b0;
    repeat (5) tick();
    checkOutput("t6_no_done", done_pulses - pulses0, 0);
    checkOutput("t6_req_idle", core_req, 0);
    setCores(3, 8'h00, 8'h00, 8'h00, 8'h33, 4'b1000);
    applyStimulus(1'b1, 1'b0, 8'h30);
    waitDone(100, seen);
    checkOutput("t6_after_done", seen, 1);
    checkOutput("t6_after_nonce", found_nonce, 8'h33);
    checkOutput("t6_after_count", hash_count, 4);
    tick();

    checkOutput("nonce_stability", unstable_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
